// File: rtl/game_pkg.sv
// game_pkg: shared constants for the frog game datapath.
//   - game_state_t : controller state encoding
//   - IMG_*        : image select codes driven to the display and comparator
//   - CODE_*       : crash/goal codes produced by the crash comparator
//   - image_for_state() : image code shown in each controller state
package game_pkg;

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_PLAY     = 3'd1,
        ST_CRASH    = 3'd2,
        ST_WIN      = 3'd3,
        ST_GAMEOVER = 3'd4
    } game_state_t;

    localparam logic [1:0] IMG_PLAY  = 2'b00;
    localparam logic [1:0] IMG_CRASH = 2'b01;
    localparam logic [1:0] IMG_END   = 2'b10;
    localparam logic [1:0] IMG_START = 2'b11;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_HIT  = 2'b01;
    localparam logic [1:0] CODE_GOAL = 2'b10;

    function automatic logic [1:0] image_for_state(input game_state_t s);
        logic [1:0] img;
        img = IMG_START;
        case (s)
            ST_START:    img = IMG_START;
            ST_PLAY:     img = IMG_PLAY;
            ST_CRASH:    img = IMG_CRASH;
            ST_WIN:      img = IMG_END;
            ST_GAMEOVER: img = IMG_END;
            default:     img = IMG_START;
        endcase
        return img;
    endfunction

endpackage

// File: rtl/sc_hold_timer.sv
// sc_hold_timer: up-counter used to time the crash and level-clear screens.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   clr_i   synchronous clear (takes priority over counting)
//   en_i    count enable
//   last_i  terminal value (hold length minus one)
//   tc_o    high while enabled and the count equals last_i
module sc_hold_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign tc_o = en_i && (count_q == last_i);

endmodule

// File: rtl/sc_game_statemachine.sv
// sc_game_statemachine: game-flow controller between the crash comparator
// and the display/sprite layer. Filters the comparator code, tracks lives
// and level, selects the displayed image and pulses the frog reset.
// Ports:
//   SC_GAMESTATEMACHINE_CLOCK_50          system clock
//   SC_GAMESTATEMACHINE_RESET_InHigh      synchronous active-high reset
//   SC_GAMESTATEMACHINE_CRASH_InBus       comparator code (00 none, 01 crash, 10 goal)
//   SC_GAMESTATEMACHINE_START_InHigh      start button level
//   SC_GAMESTATEMACHINE_IMAGE_OutBus      image select
//   SC_GAMESTATEMACHINE_WIN_Out           end-screen qualifier (1 level clear)
//   SC_GAMESTATEMACHINE_FROGRESET_OutHigh one-cycle frog reset pulse
//   SC_GAMESTATEMACHINE_LIVES_OutBus      remaining lives
//   SC_GAMESTATEMACHINE_LEVEL_OutBus      current level, 0-based
//
// state       | meaning
// ST_START    | start screen, waiting for a start edge
// ST_PLAY     | gameplay, filtering comparator codes
// ST_CRASH    | crash screen for CRASH_HOLD cycles
// ST_WIN      | level-clear screen for WIN_HOLD cycles
// ST_GAMEOVER | game-over screen, start edge returns to ST_START
module sc_game_statemachine
    import game_pkg::*;
#(
    parameter int DATAWIDTH_LIVES = 2,
    parameter int INIT_LIVES      = 3,
    parameter int DATAWIDTH_LEVEL = 3,
    parameter int MAX_LEVEL       = 7,
    parameter int DATAWIDTH_HOLD  = 26,
    parameter int CRASH_HOLD      = 50000000,
    parameter int WIN_HOLD        = 100000000,
    parameter int CONFIRM         = 2
) (
    input  logic                       SC_GAMESTATEMACHINE_CLOCK_50,
    input  logic                       SC_GAMESTATEMACHINE_RESET_InHigh,
    input  logic [1:0]                 SC_GAMESTATEMACHINE_CRASH_InBus,
    input  logic                       SC_GAMESTATEMACHINE_START_InHigh,
    output logic [1:0]                 SC_GAMESTATEMACHINE_IMAGE_OutBus,
    output logic                       SC_GAMESTATEMACHINE_WIN_Out,
    output logic                       SC_GAMESTATEMACHINE_FROGRESET_OutHigh,
    output logic [DATAWIDTH_LIVES-1:0] SC_GAMESTATEMACHINE_LIVES_OutBus,
    output logic [DATAWIDTH_LEVEL-1:0] SC_GAMESTATEMACHINE_LEVEL_OutBus
);

    // The default WIN_HOLD does not fit in 26 bits, so the timer is widened
    // to whatever the longer hold actually needs.
    localparam int NEED_C = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
    localparam int NEED_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
    localparam int NEED_H = (NEED_C > NEED_W) ? NEED_C : NEED_W;
    localparam int HOLD_W = (DATAWIDTH_HOLD > NEED_H) ? DATAWIDTH_HOLD : NEED_H;
    localparam logic [HOLD_W-1:0] CRASH_LAST = HOLD_W'(CRASH_HOLD - 1);
    localparam logic [HOLD_W-1:0] WIN_LAST   = HOLD_W'(WIN_HOLD - 1);

    localparam int CNT_W = $clog2(CONFIRM + 1);

    game_state_t                state_q, state_d;
    logic [1:0]                 image_q, image_d;
    logic                       win_q, win_d;
    logic                       frog_q, frog_d;
    logic [DATAWIDTH_LIVES-1:0] lives_q, lives_d;
    logic [DATAWIDTH_LEVEL-1:0] level_q, level_d;
    logic                       start_q;
    logic [1:0]                 fcode_q, fcode_d;
    logic [CNT_W-1:0]           fcnt_q, fcnt_d;

    logic             start_edge;
    logic             code_valid;
    logic [CNT_W-1:0] run_next;
    logic             hold_en;
    logic             hold_clr;
    logic             hold_tc;
    logic [HOLD_W-1:0] hold_last;

    sc_hold_timer #(
        .WIDTH (HOLD_W)
    ) u_hold_timer (
        .clk_i  (SC_GAMESTATEMACHINE_CLOCK_50),
        .rst_i  (SC_GAMESTATEMACHINE_RESET_InHigh),
        .clr_i  (hold_clr),
        .en_i   (hold_en),
        .last_i (hold_last),
        .tc_o   (hold_tc)
    );

    assign hold_en   = (state_q == ST_CRASH) || (state_q == ST_WIN);
    assign hold_last = (state_q == ST_WIN) ? WIN_LAST : CRASH_LAST;
    assign hold_clr  = (state_d != state_q);

    assign start_edge = SC_GAMESTATEMACHINE_START_InHigh && !start_q;
    assign code_valid = (SC_GAMESTATEMACHINE_CRASH_InBus == CODE_HIT) ||
                        (SC_GAMESTATEMACHINE_CRASH_InBus == CODE_GOAL);
    // A nonzero run of the same code extends; anything else restarts at 1.
    assign run_next   = ((SC_GAMESTATEMACHINE_CRASH_InBus == fcode_q) && (fcnt_q != '0))
                        ? fcnt_q + CNT_W'(1) : CNT_W'(1);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        frog_d  = 1'b0;
        lives_d = lives_q;
        level_d = level_q;
        fcode_d = CODE_NONE;
        fcnt_d  = '0;

        case (state_q)
            ST_START: begin
                if (start_edge) begin
                    lives_d = DATAWIDTH_LIVES'(INIT_LIVES);
                    level_d = '0;
                    state_d = ST_PLAY;
                    frog_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                // The frog-reset cycle is blind: the comparator still sees the
                // old frog position.
                if (!frog_q && code_valid) begin
                    if (run_next == CNT_W'(CONFIRM)) begin
                        if (SC_GAMESTATEMACHINE_CRASH_InBus == CODE_HIT) begin
                            lives_d = (lives_q == '0) ? '0 : lives_q - DATAWIDTH_LIVES'(1);
                            state_d = (lives_q <= DATAWIDTH_LIVES'(1)) ? ST_GAMEOVER : ST_CRASH;
                        end else begin
                            state_d = ST_WIN;
                        end
                    end else begin
                        fcode_d = SC_GAMESTATEMACHINE_CRASH_InBus;
                        fcnt_d  = run_next;
                    end
                end
            end
            ST_CRASH: begin
                if (hold_tc) begin
                    state_d = ST_PLAY;
                    frog_d  = 1'b1;
                end
            end
            ST_WIN: begin
                if (hold_tc) begin
                    if (level_q != DATAWIDTH_LEVEL'(MAX_LEVEL)) begin
                        level_d = level_q + DATAWIDTH_LEVEL'(1);
                    end
                    state_d = ST_PLAY;
                    frog_d  = 1'b1;
                end
            end
            ST_GAMEOVER: begin
                if (start_edge) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        if (state_d != state_q) begin
            if (state_d == ST_WIN) begin
                win_d = 1'b1;
            end else if (state_d != ST_CRASH) begin
                win_d = 1'b0;
            end
        end

        image_d = image_for_state(state_d);
    end

    always_ff @(posedge SC_GAMESTATEMACHINE_CLOCK_50) begin
        if (SC_GAMESTATEMACHINE_RESET_InHigh) begin
            state_q <= ST_START;
            image_q <= IMG_START;
            win_q   <= 1'b0;
            frog_q  <= 1'b0;
            lives_q <= DATAWIDTH_LIVES'(INIT_LIVES);
            level_q <= '0;
            start_q <= 1'b0;
            fcode_q <= CODE_NONE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            image_q <= image_d;
            win_q   <= win_d;
            frog_q  <= frog_d;
            lives_q <= lives_d;
            level_q <= level_d;
            start_q <= SC_GAMESTATEMACHINE_START_InHigh;
            fcode_q <= fcode_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign SC_GAMESTATEMACHINE_IMAGE_OutBus      = image_q;
    assign SC_GAMESTATEMACHINE_WIN_Out           = win_q;
    assign SC_GAMESTATEMACHINE_FROGRESET_OutHigh = frog_q;
    assign SC_GAMESTATEMACHINE_LIVES_OutBus      = lives_q;
    assign SC_GAMESTATEMACHINE_LEVEL_OutBus      = level_q;

endmodule

// File: tb/tb_sc_game_statemachine.sv
module tb_sc_game_statemachine;

    logic       clk;
    logic       rst;
    logic [1:0] crash;
    logic       start;
    logic [1:0] image;
    logic       win;
    logic       frog;
    logic [1:0] lives;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    sc_game_statemachine #(
        .DATAWIDTH_LIVES (2),
        .INIT_LIVES      (3),
        .DATAWIDTH_LEVEL (3),
        .MAX_LEVEL       (7),
        .DATAWIDTH_HOLD  (26),
        .CRASH_HOLD      (4),
        .WIN_HOLD        (3),
        .CONFIRM         (2)
    ) dut (
        .SC_GAMESTATEMACHINE_CLOCK_50          (clk),
        .SC_GAMESTATEMACHINE_RESET_InHigh      (rst),
        .SC_GAMESTATEMACHINE_CRASH_InBus       (crash),
        .SC_GAMESTATEMACHINE_START_InHigh      (start),
        .SC_GAMESTATEMACHINE_IMAGE_OutBus      (image),
        .SC_GAMESTATEMACHINE_WIN_Out           (win),
        .SC_GAMESTATEMACHINE_FROGRESET_OutHigh (frog),
        .SC_GAMESTATEMACHINE_LIVES_OutBus      (lives),
        .SC_GAMESTATEMACHINE_LEVEL_OutBus      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; outputs are then examined 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a clean PLAY cycle: goal for CONFIRM cycles, WIN for 3 cycles,
    // ends observing the frog-reset cycle.
    task automatic do_goal(input logic [2:0] exp_level);
        crash = 2'b10;
        step();
        check("goal_pending_img", image, 2'b00);
        step();
        check("goal_img", image, 2'b10);
        check("goal_win", win, 1'b1);
        crash = 2'b00;
        step();
        check("win_hold1_img", image, 2'b10);
        step();
        check("win_hold2_img", image, 2'b10);
        check("win_hold2_win", win, 1'b1);
        step();
        check("win_exit_img", image, 2'b00);
        check("win_exit_frog", frog, 1'b1);
        check("win_exit_level", level, exp_level);
        check("win_exit_win", win, 1'b0);
    endtask

    // From a clean PLAY cycle: crash accepted, 4-cycle hold, ends observing
    // the frog-reset cycle.
    task automatic do_crash(input logic [1:0] exp_lives);
        crash = 2'b01;
        step();
        check("crash_pending_img", image, 2'b00);
        step();
        check("crash_img", image, 2'b01);
        check("crash_lives", lives, exp_lives);
        crash = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("crash_hold_img", image, 2'b01);
        end
        step();
        check("crash_exit_img", image, 2'b00);
        check("crash_exit_frog", frog, 1'b1);
    endtask

    task automatic idle_after_frog();
        step();
        check("frog_once", frog, 1'b0);
        check("play_img", image, 2'b00);
    endtask

    initial begin
        rst   = 1'b1;
        crash = 2'b00;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_img", image, 2'b11);
        check("rst_win", win, 1'b0);
        check("rst_frog", frog, 1'b0);
        check("rst_lives", lives, 2'd3);
        check("rst_level", level, 3'd0);
        step();
        check("start_wait_img", image, 2'b11);

        // Start pulse
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_img", image, 2'b00);
        check("start_frog", frog, 1'b1);
        check("start_lives", lives, 2'd3);
        check("start_level", level, 3'd0);
        idle_after_frog();

        // Single-cycle crash code is filtered out
        crash = 2'b01;
        step();
        crash = 2'b00;
        step();
        check("glitch_img", image, 2'b00);
        check("glitch_lives", lives, 2'd3);

        do_crash(2'd2);
        idle_after_frog();

        // Eight level clears; level saturates at 7
        for (int n = 1; n <= 7; n++) begin
            do_goal(3'(n));
            idle_after_frog();
        end
        do_goal(3'd7);

        // Crash code present during the frog-reset cycle is ignored
        crash = 2'b01;
        step();
        check("mask_frog_img", image, 2'b00);
        step();
        check("mask_first_img", image, 2'b00);
        step();
        check("mask_accept_img", image, 2'b01);
        check("mask_accept_lives", lives, 2'd1);
        crash = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mask_hold_img", image, 2'b01);
        end
        step();
        check("mask_exit_frog", frog, 1'b1);
        idle_after_frog();

        // 01,10,10: goal accepted on third sample
        crash = 2'b01;
        step();
        crash = 2'b10;
        step();
        check("switch_img", image, 2'b00);
        step();
        check("switch_goal_img", image, 2'b10);
        check("switch_goal_win", win, 1'b1);
        crash = 2'b00;
        step();
        step();
        step();
        check("switch_exit_img", image, 2'b00);
        check("switch_exit_level", level, 3'd7);
        check("switch_exit_lives", lives, 2'd1);
        idle_after_frog();

        // 01,00,01: nothing accepted
        crash = 2'b01;
        step();
        crash = 2'b00;
        step();
        crash = 2'b01;
        step();
        crash = 2'b00;
        step();
        check("broken_img", image, 2'b00);
        check("broken_lives", lives, 2'd1);

        // 11 is treated as no code
        crash = 2'b11;
        step();
        step();
        crash = 2'b00;
        check("code11_img", image, 2'b00);

        // Last life lost
        crash = 2'b01;
        step();
        step();
        crash = 2'b00;
        check("over_img", image, 2'b10);
        check("over_win", win, 1'b0);
        check("over_lives", lives, 2'd0);
        step();
        step();
        check("over_stay_img", image, 2'b10);

        // Held start: one edge goes to START only
        start = 1'b1;
        step();
        check("held_start_img", image, 2'b11);
        for (int i = 0; i < 9; i++) begin
            step();
            check("held_img", image, 2'b11);
            check("held_frog", frog, 1'b0);
        end
        start = 1'b0;
        step();
        check("release_img", image, 2'b11);

        // New game
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_img", image, 2'b00);
        check("restart_lives", lives, 2'd3);
        check("restart_level", level, 3'd0);
        idle_after_frog();
        do_goal(3'd1);
        idle_after_frog();

        // Reset in the middle of the crash hold
        crash = 2'b01;
        step();
        step();
        crash = 2'b00;
        check("pre_rst_img", image, 2'b01);
        check("pre_rst_lives", lives, 2'd2);
        step();
        rst = 1'b1;
        step();
        check("midrst_img", image, 2'b11);
        check("midrst_lives", lives, 2'd3);
        check("midrst_level", level, 3'd0);
        check("midrst_frog", frog, 1'b0);
        check("midrst_win", win, 1'b0);
        rst = 1'b0;
        step();
        step();
        check("post_rst_img", image, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
